// File: rtl/draw_pkg.sv
// Shared drawing-path definitions: VGA framebuffer geometry, pixel field
// widths, the pixel bundle and the plot arbiter state encoding.
package draw_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 3;

  // Visible area is 160x120; anything at or beyond these bounds is dropped.
  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/plot_arbiter_if.sv
// Engine-side request/pixel bus plus the VGA pixel-write port.
//   req/pix_valid/pix_last : per-engine handshake (one bit per engine)
//   x_in/y_in/color_in     : per-engine pixel data, engine i in entry [i]
//   grant                  : one-hot burst grant back to the engines
//   x/y/color/plot         : registered write port toward vga_adapter
// master = drawing engines side, slave = arbiter.
interface plot_arbiter_if
  import draw_pkg::*;
#(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]              req;
  logic [N_REQ-1:0]              pix_valid;
  logic [N_REQ-1:0]              pix_last;
  logic [N_REQ-1:0][X_W-1:0]     x_in;
  logic [N_REQ-1:0][Y_W-1:0]     y_in;
  logic [N_REQ-1:0][COLOR_W-1:0] color_in;
  logic [N_REQ-1:0]              grant;
  logic [X_W-1:0]                x;
  logic [Y_W-1:0]                y;
  logic [COLOR_W-1:0]            color;
  logic                          plot;

  modport master (
    output req, pix_valid, pix_last, x_in, y_in, color_in,
    input  grant, x, y, color, plot
  );

  modport slave (
    input  req, pix_valid, pix_last, x_in, y_in, color_in,
    output grant, x, y, color, plot
  );
endinterface

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index holding highest priority this round
//   win   : one-hot winner (first set bit at or after ptr, wrapping)
//   valid : at least one request present
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin burst arbiter for the single vga_adapter pixel-write port.
//   clock       : system clock
//   reset       : synchronous, active-low
//   bus         : engine handshake/pixel bus and VGA write port (slave)
//   busy        : state is GRANT or GAP
//   timeout_err : sticky, set when a burst is force-released at MAX_BURST
// Engines hold req for a whole burst; the granted engine streams one pixel
// per cycle, which appears on the VGA port exactly one cycle later.
module plot_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 19200
) (
  input  logic            clock,
  input  logic            reset,
  plot_arbiter_if.slave   bus,
  output logic            busy,
  output logic            timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e       state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    gidx, gidx_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  pixel_t           pix_q, pix_nxt;
  logic             plot_q, plot_nxt;
  logic             err_q, err_nxt;
  logic             busy_q, busy_nxt;

  logic [N_REQ-1:0] pick_win;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;

  logic             g_valid, g_last, g_req, onscreen, fin;
  pixel_t           g_pix;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_win[i]) pick_idx = PW'(i);
  end

  // Only the granted engine's lanes are looked at.
  assign g_valid  = bus.pix_valid[gidx];
  assign g_last   = bus.pix_last[gidx];
  assign g_req    = bus.req[gidx];
  assign g_pix    = '{x: bus.x_in[gidx], y: bus.y_in[gidx], color: bus.color_in[gidx]};
  assign onscreen = (g_pix.x < SCREEN_W) && (g_pix.y < SCREEN_H);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    cnt_nxt   = cnt;
    grant_nxt = grant_q;
    pix_nxt   = pix_q;
    plot_nxt  = 1'b0;
    err_nxt   = err_q;
    fin       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick_win;
          gidx_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end

      ST_GRANT: begin
        pix_nxt  = g_pix;
        // Off-screen pixels are swallowed but still consume burst budget.
        plot_nxt = g_valid & onscreen;
        if (g_valid) cnt_nxt = cnt + CW'(1);

        // last beats the length limit, which beats abandonment.
        if (g_valid && g_last) begin
          fin = 1'b1;
        end else if (g_valid && cnt == CW'(MAX_BURST - 1)) begin
          fin     = 1'b1;
          err_nxt = 1'b1;
        end else if (!g_valid && !g_req) begin
          fin = 1'b1;
        end

        if (fin) begin
          state_nxt = ST_GAP;
          grant_nxt = '0;
          ptr_nxt   = PW'((int'(gidx) + 1) % N_REQ);
        end
      end

      ST_GAP: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Registered so busy tracks the state register exactly.
  assign busy_nxt = (state_nxt != ST_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      cnt     <= '0;
      grant_q <= '0;
      pix_q   <= '0;
      plot_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gidx    <= gidx_nxt;
      cnt     <= cnt_nxt;
      grant_q <= grant_nxt;
      pix_q   <= pix_nxt;
      plot_q  <= plot_nxt;
      err_q   <= err_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.x       = pix_q.x;
  assign bus.y       = pix_q.y;
  assign bus.color   = pix_q.color;
  assign bus.plot    = plot_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;
  import draw_pkg::*;

  localparam int N  = 3;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy, timeout_err;

  plot_arbiter_if #(.N_REQ(N)) bus ();

  plot_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int vecs  = 0;
  int errs  = 0;
  int plots = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every plot strobe must match the oldest expected pixel.
  always @(negedge clock) begin
    if (bus.plot === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_plot", {bus.x, bus.y, bus.color}, 32'hFFFF_FFFF);
      else chk("pixel", {bus.x, bus.y, bus.color}, exp_q.pop_front());
      plots++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, output int n);
    n = 0;
    while (bus.grant == '0 && n < 8) begin
      step();
      n++;
    end
    chk("grant", 32'(bus.grant), 32'(exp));
  endtask

  task automatic drive_pix(input int i, input logic [7:0] px, input logic [6:0] py,
                           input logic [2:0] pc, input logic last, input logic expect_plot);
    bus.pix_valid   = '0;
    bus.pix_last    = '0;
    bus.pix_valid[i] = 1'b1;
    bus.pix_last[i]  = last;
    bus.x_in[i]     = px;
    bus.y_in[i]     = py;
    bus.color_in[i] = pc;
    if (expect_plot) exp_q.push_back({px, py, pc});
  endtask

  task automatic idle_pix();
    bus.pix_valid = '0;
    bus.pix_last  = '0;
  endtask

  int n;
  int p0;
  int sidx[4] = '{0, 1, 2, 0};

  initial begin
    bus.req = '0; bus.pix_valid = '0; bus.pix_last = '0;
    bus.x_in = '0; bus.y_in = '0; bus.color_in = '0;

    // 1: reset with all requesting
    bus.req = 3'b111;
    step(); step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_xyc", {bus.x, bus.y, bus.color}, 0);
    reset = 1'b1;
    step();
    chk("first_grant", 32'(bus.grant), 32'b001);
    chk("first_busy", 32'(busy), 1);

    // 2: requester 0 streams 4 pixels
    bus.req = 3'b001;
    p0 = plots;
    for (int i = 0; i < 4; i++) begin
      drive_pix(0, 8'(i), 7'd5, 3'b100, i == 3, 1'b1);
      step();
      chk("stream_plot", 32'(bus.plot), 1);
    end
    idle_pix();
    bus.req = '0;
    chk("t2_grant_drop", 32'(bus.grant), 0);
    chk("t2_busy_gap", 32'(busy), 1);
    step();
    chk("t2_plot_gap", 32'(bus.plot), 0);
    chk("t2_busy_idle", 32'(busy), 0);
    chk("t2_plot_count", 32'(plots - p0), 4);

    // 3: everybody requesting, single-pixel bursts, pointer restarted by reset
    reset = 1'b0;
    bus.req = 3'b111;
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(3'(1 << sidx[k]), n);
      if (k > 0) chk("rr_gap", 32'(n), 2);
      drive_pix(sidx[k], 8'(10 * k), 7'd1, 3'(k + 1), 1'b1, 1'b1);
      step();
      idle_pix();
      if (k == 3) bus.req = '0;
    end
    step(); step();
    chk("t3_busy_done", 32'(busy), 0);

    // 4: requester 1 overruns MAX_BURST
    bus.req = 3'b010;
    wait_grant(3'b010, n);
    for (int i = 0; i < 5; i++) begin
      drive_pix(1, 8'(20 + i), 7'd7, 3'b010, 1'b0, i < MB);
      step();
      if (i == MB - 1) begin
        chk("to_grant_drop", 32'(bus.grant), 0);
        chk("to_err_set", 32'(timeout_err), 1);
      end
    end
    idle_pix();
    bus.req = '0;
    step(); step();
    chk("to_err_held", 32'(timeout_err), 1);
    chk("to_no_regrant", 32'(bus.grant), 0);

    // 5: off-screen pixel dropped, on-screen edge pixel kept
    bus.req = 3'b100;
    wait_grant(3'b100, n);
    drive_pix(2, 8'd160, 7'd10, 3'b111, 1'b0, 1'b0);
    step();
    chk("offscreen_plot", 32'(bus.plot), 0);
    drive_pix(2, 8'd159, 7'd119, 3'b101, 1'b1, 1'b1);
    step();
    chk("edge_plot", 32'(bus.plot), 1);
    chk("t5_release", 32'(bus.grant), 0);
    idle_pix();
    bus.req = '0;
    step(); step();

    // 6: reset during the 2nd pixel of a burst
    bus.req = 3'b010;
    wait_grant(3'b010, n);
    drive_pix(1, 8'd40, 7'd40, 3'b011, 1'b0, 1'b1);
    step();
    drive_pix(1, 8'd41, 7'd40, 3'b011, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_plot", 32'(bus.plot), 0);
    chk("mid_rst_xyc", {bus.x, bus.y, bus.color}, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(timeout_err), 0);
    idle_pix();
    bus.req = 3'b111;
    reset = 1'b1;
    step();
    chk("post_rst_ptr", 32'(bus.grant), 32'b001);
    bus.req = '0;
    step(); step(); step();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
